// File: rtl/rx_destripe_pkg.sv
// Shared constants and types for the four-lane receive destriper.
package rx_destripe_pkg;

    // Alignment/control symbol carried on every lane at the same time.
    localparam logic [7:0] COM_DEFAULT = 8'hBC;

    // Number of serial lanes. Lane k carries stream bytes 4n+k.
    localparam int NUM_LANES = 4;

    // Bit position inside the current byte while locked (8 bits per byte).
    localparam int PHASE_W = 3;

    // Emission step counter. Idle at 0, otherwise steps 1..7 after a capture.
    localparam int EMIT_W = 3;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/rx_destripe_serie_paralelo.sv
// One lane deserializer: an MSB-first 8-bit shift register plus a COM detector.
module serie_paralelo
    import rx_destripe_pkg::*;
#(
    parameter logic [7:0] COM = COM_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lane_in,
    output logic [7:0] sr,
    output logic       match
);

    logic [7:0] sr_d;
    logic [7:0] sr_q;

    // New bit enters at the LSB, so the first bit of a byte ends up in bit 7.
    always_comb begin
        sr_d = {sr_q[6:0], lane_in};
    end

    // Shift every cycle, whether or not the receiver is aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr    = sr_q;
    assign match = (sr_q == COM);

endmodule

// File: rtl/rx_destripe.sv
// Four-lane destriper: aligns on a simultaneous COM on all lanes, then
// captures one byte per lane every 8 cycles and replays them in lane order.
// Output strobe: valid is a single-cycle pulse per byte; there is no ready,
// the consumer must take data_out/ctrl in every cycle where valid is high.
module rx_destripe
    import rx_destripe_pkg::*;
#(
    parameter logic [7:0] COM = COM_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       L0,
    input  logic       L1,
    input  logic       L2,
    input  logic       L3,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       ctrl,
    output logic       locked,
    output logic       align_err
);

    logic [NUM_LANES-1:0] lane_bits;
    logic [7:0]           sr [NUM_LANES];
    logic [NUM_LANES-1:0] match;

    assign lane_bits = {L3, L2, L1, L0};

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        serie_paralelo #(.COM(COM)) u_sp (
            .clk     (clk),
            .reset   (reset),
            .lane_in (lane_bits[gi]),
            .sr      (sr[gi]),
            .match   (match[gi])
        );
    end

    state_e              state_q, state_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [EMIT_W-1:0]   emit_cnt_q, emit_cnt_d;
    logic [7:0]          hold_q [NUM_LANES];
    logic [7:0]          hold_d [NUM_LANES];
    logic [7:0]          data_out_q, data_out_d;
    logic                valid_q, valid_d;
    logic                ctrl_q, ctrl_d;
    logic                align_err_q, align_err_d;
    logic                capture;
    logic                all_com;
    logic                no_com;

    assign all_com = &match;
    assign no_com  = (match == '0);

    // Alignment FSM, phase counter, group capture and the lane-order replay.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        emit_cnt_d  = emit_cnt_q;
        data_out_d  = data_out_q;
        valid_d     = 1'b0;
        ctrl_d      = 1'b0;
        align_err_d = 1'b0;
        capture     = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            hold_d[k] = hold_q[k];
        end

        // Lane 0 goes out straight from sr at the capture edge; lanes 1..3
        // follow from the hold registers on even steps 2, 4, 6.
        if (emit_cnt_q != '0) begin
            emit_cnt_d = emit_cnt_q + 3'd1;
            if (!emit_cnt_q[0]) begin
                data_out_d = hold_q[emit_cnt_q[2:1]];
                valid_d    = 1'b1;
                ctrl_d     = (hold_q[emit_cnt_q[2:1]] == COM);
            end
        end

        case (state_q)
            SEARCH: begin
                phase_d = '0;
                if (all_com) begin
                    state_d = LOCKED;
                    phase_d = 3'd1;
                    capture = 1'b1;
                end else if (!no_com) begin
                    align_err_d = 1'b1;
                end
            end
            LOCKED: begin
                phase_d = phase_q + 3'd1;
                if (phase_q == '0) begin
                    if (all_com || no_com) begin
                        capture = 1'b1;
                    end else begin
                        // Lanes disagree about COM: drop the group and realign.
                        align_err_d = 1'b1;
                        state_d     = SEARCH;
                        phase_d     = '0;
                    end
                end
            end
            default: begin
                state_d = SEARCH;
                phase_d = '0;
            end
        endcase

        if (capture) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                hold_d[k] = sr[k];
            end
            data_out_d = sr[0];
            valid_d    = 1'b1;
            ctrl_d     = match[0];
            emit_cnt_d = 3'd1;
        end
    end

    // State and output registers; reset drops any partial group.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= SEARCH;
            phase_q     <= '0;
            emit_cnt_q  <= '0;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            ctrl_q      <= 1'b0;
            align_err_q <= 1'b0;
            for (int k = 0; k < NUM_LANES; k++) begin
                hold_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            emit_cnt_q  <= emit_cnt_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            ctrl_q      <= ctrl_d;
            align_err_q <= align_err_d;
            for (int k = 0; k < NUM_LANES; k++) begin
                hold_q[k] <= hold_d[k];
            end
        end
    end

    assign data_out  = data_out_q;
    assign valid     = valid_q;
    assign ctrl      = ctrl_q;
    assign align_err = align_err_q;
    assign locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_rx_destripe.sv
// Bench for rx_destripe: lane driver, scoreboard monitor and per-scenario tasks.
module tb_rx_destripe;

    localparam logic [7:0] COM_SYM = 8'hBC;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       L0 = 1'b0, L1 = 1'b0, L2 = 1'b0, L3 = 1'b0;
    logic [7:0] data_out;
    logic       valid, ctrl, locked, align_err;

    int          vectors     = 0;
    int          miscompares = 0;
    int unsigned cyc         = 0;

    // Scoreboard: {ctrl, byte} and the cycle it must appear in.
    logic [8:0]  exp_q[$];
    int unsigned exp_cyc_q[$];
    int unsigned err_cyc_q[$];
    int unsigned lock_rise_cyc = 0;
    int unsigned lock_fall_cyc = 0;
    int          lock_rises    = 0;
    int          lock_falls    = 0;
    int          pops          = 0;

    rx_destripe dut (
        .clk       (clk),
        .reset     (reset),
        .L0        (L0),
        .L1        (L1),
        .L2        (L2),
        .L3        (L3),
        .data_out  (data_out),
        .valid     (valid),
        .ctrl      (ctrl),
        .locked    (locked),
        .align_err (align_err)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        logic       locked_prev;
        logic [8:0] exp_v;
        int unsigned exp_c;
        locked_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (align_err === 1'b1) err_cyc_q.push_back(cyc);
            if (locked === 1'b1 && !locked_prev) begin
                lock_rises++;
                lock_rise_cyc = cyc;
            end
            if (locked !== 1'b1 && locked_prev) begin
                lock_falls++;
                lock_fall_cyc = cyc;
            end
            locked_prev = (locked === 1'b1);
            if (valid !== 1'b0) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_valid cyc=%0d valid=%b data_out=%h, required no output", cyc, valid, data_out);
                end else begin
                    exp_v = exp_q.pop_front();
                    exp_c = exp_cyc_q.pop_front();
                    pops++;
                    if ({ctrl, data_out} !== exp_v || cyc != exp_c) begin
                        miscompares++;
                        $display("FAIL byte_out cyc=%0d ctrl=%b data_out=%h, required cyc=%0d ctrl=%b data_out=%h",
                                 cyc, ctrl, data_out, exp_c, exp_v[8], exp_v[7:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1;
        {L3, L2, L1, L0} = 4'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        exp_cyc_q.delete();
        reset = 1'b0;
    endtask

    // Drives one byte per lane MSB-first; p is the edge that samples the last bit.
    task automatic send_group(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3,
                              input bit expect_out, output int unsigned p);
        logic [7:0] b [4];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            L0 = b0[i]; L1 = b1[i]; L2 = b2[i]; L3 = b3[i];
        end
        p = cyc + 1;
        if (expect_out) begin
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back({(b[k] == COM_SYM), b[k]});
                exp_cyc_q.push_back(p + 1 + 2 * k);
            end
        end
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while (n < limit) begin
            @(negedge clk);
            {L3, L2, L1, L0} = 4'b0;
            n++;
            if (exp_q.size() == 0) break;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout pending=%0d, required 0", exp_q.size());
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        vectors++; if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data_out got=%h required=00", data_out); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got=%b required=0", valid); end
        vectors++; if (ctrl !== 1'b0) begin miscompares++; $display("FAIL reset_ctrl got=%b required=0", ctrl); end
        vectors++; if (locked !== 1'b0) begin miscompares++; $display("FAIL reset_locked got=%b required=0", locked); end
        vectors++; if (align_err !== 1'b0) begin miscompares++; $display("FAIL reset_align_err got=%b required=0", align_err); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            vectors++;
            if (locked !== 1'b0 || valid !== 1'b0 || align_err !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_zero cyc=%0d locked=%b valid=%b align_err=%b, required 0 0 0", cyc, locked, valid, align_err);
            end
        end
    endtask

    task automatic test_lock_data();
        int unsigned p1, p2;
        int          r0;
        do_reset();
        err_cyc_q.delete();
        r0 = lock_rises;
        send_group(COM_SYM, COM_SYM, COM_SYM, COM_SYM, 1, p1);
        send_group(8'h01, 8'h02, 8'h03, 8'h04, 1, p2);
        wait_drain(24);
        vectors++;
        if (lock_rises != r0 + 1 || lock_rise_cyc != p1 + 1) begin
            miscompares++;
            $display("FAIL lock_rise rises=%0d cyc=%0d, required rises=%0d cyc=%0d", lock_rises - r0, lock_rise_cyc, 1, p1 + 1);
        end
        vectors++;
        if (locked !== 1'b1) begin miscompares++; $display("FAIL lock_hold got=%b required=1", locked); end
        vectors++;
        if (err_cyc_q.size() != 0) begin miscompares++; $display("FAIL lock_no_err count=%0d required=0", err_cyc_q.size()); end
    endtask

    task automatic test_skew();
        logic [15:0] s0, s3;
        int unsigned p;
        int          r0;
        do_reset();
        err_cyc_q.delete();
        r0 = lock_rises;
        s0 = {COM_SYM, 8'h00};
        s3 = {1'b0, COM_SYM, 7'h00};
        p  = 0;
        for (int i = 15; i >= 0; i--) begin
            @(negedge clk);
            L0 = s0[i]; L1 = s0[i]; L2 = s0[i]; L3 = s3[i];
            if (i == 8) p = cyc + 1;
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (err_cyc_q.size() != 2) begin
            miscompares++;
            $display("FAIL skew_err_count got=%0d required=2", err_cyc_q.size());
        end else begin
            vectors++;
            if (err_cyc_q[0] != p + 1 || err_cyc_q[1] != p + 2) begin
                miscompares++;
                $display("FAIL skew_err_cyc got=%0d,%0d required=%0d,%0d", err_cyc_q[0], err_cyc_q[1], p + 1, p + 2);
            end
        end
        vectors++;
        if (lock_rises != r0 || locked !== 1'b0) begin
            miscompares++;
            $display("FAIL skew_no_lock rises=%0d locked=%b, required 0 0", lock_rises - r0, locked);
        end
    endtask

    task automatic test_partial_com();
        int unsigned p1, p2, p3, p4, p5;
        int          f0;
        do_reset();
        err_cyc_q.delete();
        f0 = lock_falls;
        send_group(COM_SYM, COM_SYM, COM_SYM, COM_SYM, 1, p1);
        send_group(8'h11, 8'h22, 8'h33, 8'h44, 1, p2);
        send_group(COM_SYM, 8'h55, COM_SYM, 8'h55, 0, p3);
        send_group(COM_SYM, COM_SYM, COM_SYM, COM_SYM, 1, p4);
        send_group(8'hA1, 8'hB2, 8'hC3, 8'hD4, 1, p5);
        wait_drain(24);
        vectors++;
        if (err_cyc_q.size() != 1) begin
            miscompares++;
            $display("FAIL partial_err_count got=%0d required=1", err_cyc_q.size());
        end else begin
            vectors++;
            if (err_cyc_q[0] != p3 + 1) begin
                miscompares++;
                $display("FAIL partial_err_cyc got=%0d required=%0d", err_cyc_q[0], p3 + 1);
            end
        end
        vectors++;
        if (lock_falls != f0 + 1 || lock_fall_cyc != p3 + 1) begin
            miscompares++;
            $display("FAIL partial_unlock falls=%0d cyc=%0d, required falls=1 cyc=%0d", lock_falls - f0, lock_fall_cyc, p3 + 1);
        end
        vectors++;
        if (lock_rise_cyc != p4 + 1 || locked !== 1'b1) begin
            miscompares++;
            $display("FAIL partial_relock cyc=%0d locked=%b, required cyc=%0d locked=1", lock_rise_cyc, locked, p4 + 1);
        end
    endtask

    task automatic test_reset_mid_emission();
        int unsigned p1, p2;
        int          n, pops0, r0;
        do_reset();
        pops0 = pops;
        send_group(COM_SYM, COM_SYM, COM_SYM, COM_SYM, 1, p1);
        send_group(8'hAA, 8'hBB, 8'hCC, 8'hDD, 1, p2);
        n = 0;
        while (cyc != p2 + 3 && n < 20) begin
            @(negedge clk);
            {L3, L2, L1, L0} = 4'b0;
            n++;
        end
        vectors++;
        if (cyc != p2 + 3) begin miscompares++; $display("FAIL mid_wait_timeout cyc=%0d required=%0d", cyc, p2 + 3); end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (data_out !== 8'h00 || valid !== 1'b0 || ctrl !== 1'b0 || locked !== 1'b0 || align_err !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_outputs data_out=%h valid=%b ctrl=%b locked=%b align_err=%b, required 00 0 0 0 0",
                     data_out, valid, ctrl, locked, align_err);
        end
        vectors++;
        if (pops - pops0 != 6) begin miscompares++; $display("FAIL mid_bytes_before_reset got=%0d required=6", pops - pops0); end
        exp_q.delete();
        exp_cyc_q.delete();
        reset = 1'b0;
        r0 = lock_rises;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            vectors++;
            if (valid !== 1'b0) begin miscompares++; $display("FAIL mid_no_valid cyc=%0d got=%b required=0", cyc, valid); end
        end
        vectors++;
        if (lock_rises != r0) begin miscompares++; $display("FAIL mid_no_relock rises=%0d required=0", lock_rises - r0); end
    endtask

    task automatic test_long_stream();
        logic [7:0]  b [4];
        int unsigned p;
        int          pops0;
        do_reset();
        err_cyc_q.delete();
        pops0 = pops;
        for (int g = 0; g < 64; g++) begin
            for (int k = 0; k < 4; k++) begin
                if (g % 8 == 0) begin
                    b[k] = COM_SYM;
                end else begin
                    b[k] = 8'($urandom_range(0, 255));
                    while (b[k] == COM_SYM) b[k] = 8'($urandom_range(0, 255));
                end
            end
            send_group(b[0], b[1], b[2], b[3], 1, p);
        end
        wait_drain(40);
        vectors++;
        if (pops - pops0 != 256) begin miscompares++; $display("FAIL long_byte_count got=%0d required=256", pops - pops0); end
        vectors++;
        if (err_cyc_q.size() != 0) begin miscompares++; $display("FAIL long_no_err count=%0d required=0", err_cyc_q.size()); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_lock_data();
        test_skew();
        test_partial_com();
        test_reset_mid_emission();
        test_long_stream();
        do_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
